seq_detect_prog: RTL and testbench

// - Programmable serial bit-sequence detector. It replaces fixed-pattern Mealy detectors such as the hard-wired "1011" detector.
// - Pattern, pattern length and overlap mode are loaded at runtime. Each hit gives a registered match pulse, and a saturating counter totals the hits.
// - Sits on a serial data path behind a bit-valid qualifier. Its outputs feed the status/interrupt logic.
//

---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_match_cmp.sv | 28 ++
 rtl/seq_detect_prog.sv | 138 +++++++++++++
 tb/tb_seq_detect_prog.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the programmable serial sequence detector family:
// state encoding, default sizes and the pattern-length mask helper.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_PAT_W  = 8;
  localparam int DEF_CNT_W  = 16;
  // Widest pattern the mask helper can describe; callers truncate to PAT_W.
  localparam int MASK_MAX_W = 64;

  // Low `len` bits set, all others clear.
  function automatic logic [MASK_MAX_W-1:0] mask(input int len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational masked compare of the candidate window against the loaded
// pattern, qualified by enough history having been collected.
module seq_match_cmp
  import seq_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] cand,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] fill,
  output logic             hit
);

  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_p1;
  logic             fill_ok;

  // The incoming bit counts toward the fill, so compare fill+1 against len.
  always_comb begin
    len_mask = PAT_W'(mask(int'(len)));
    fill_p1  = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    fill_ok  = (fill_p1 >= {1'b0, len});
    hit      = fill_ok && (((cand ^ pattern) & len_mask) == '0);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector: runtime-loaded pattern, length
// and overlap mode, registered match pulse and saturating hit counter.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat,
  output logic             armed,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] cand;
  logic             hit_raw;
  logic             len_legal;
  logic [LEN_W-1:0] fill_inc;

  assign cand      = {hist_q, din};
  assign len_legal = (cfg_len != '0) && (cfg_len <= PAT_W_L);
  assign fill_inc  = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_W'(1);

  seq_match_cmp #(
    .PAT_W (PAT_W)
  ) u_cmp (
    .cand    (cand),
    .pattern (pat_q),
    .len     (len_q),
    .fill    (fill_q),
    .hit     (hit_raw)
  );

  // Next-state: configuration load, bit shifting, match and counter update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    err_d   = err_q;

    if (cfg_load) begin
      // A bit arriving together with a load is dropped on purpose.
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = len_legal ? RUN : IDLE;
      err_d   = !len_legal;
    end else if ((state_q == RUN) && din_valid) begin
      hist_d  = cand[PAT_W-2:0];
      fill_d  = (hit_raw && !ovl_q) ? '0 : fill_inc;
      match_d = hit_raw;
    end

    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match_d) begin
      cnt_d = sat_inc(cnt_q);
      sat_d = sat_q | (cnt_d == '1);
    end

    armed_d = (state_d == RUN);
  end

  // State and datapath registers; async reset discards any partial match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cnt_sat     = sat_q;
  assign armed       = armed_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed and random bench for seq_detect_prog with a bit-queue reference
// model feeding an expected-match scoreboard.
module tb_seq_detect_prog;

  localparam int PAT_W   = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_valid;
  logic             din;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             cnt_sat;
  logic             armed;
  logic             cfg_err;

  seq_detect_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count),
    .cnt_sat     (cnt_sat),
    .armed       (armed),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_armed, m_err, m_sat;
  int         m_cnt;
  int         m_hits;
  int         dut_hits;
  bit         exp_match_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    exp_match_q.delete();
    m_pat   = '0;
    m_len   = 0;
    m_ovl   = 0;
    m_armed = 0;
    m_err   = 0;
    m_sat   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit ld, input bit clr, output bit hit);
    hit = 0;
    if (ld) begin
      m_pat   = cfg_pattern;
      m_len   = int'(cfg_len);
      m_ovl   = cfg_overlap;
      m_armed = (m_len >= 1) && (m_len <= PAT_W);
      m_err   = !m_armed;
      m_bits.delete();
    end else if (m_armed && v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - m_len + i] != m_pat[m_len-1-i]) hit = 0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (hit) m_hits++;
    if (clr) begin
      m_cnt = 0;
      m_sat = 0;
    end else if (hit) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_cnt == CNT_MAX) m_sat = 1;
    end
  endtask

  task automatic step(input bit v, input bit d, input bit ld = 0, input bit clr = 0,
                      input string tag = "step");
    bit h;
    bit e;
    din_valid = v;
    din       = d;
    cfg_load  = ld;
    cnt_clr   = clr;
    model_step(v, d, ld, clr, h);
    exp_match_q.push_back(h);
    @(posedge clk);
    #1;
    e = exp_match_q.pop_front();
    if (match === 1'b1) dut_hits++;
    chk({tag, ".match"}, 32'(match), 32'(e));
    chk({tag, ".count"}, 32'(match_count), 32'(m_cnt));
    chk({tag, ".sat"},   32'(cnt_sat), 32'(m_sat));
    chk({tag, ".armed"}, 32'(armed), 32'(m_armed));
    chk({tag, ".err"},   32'(cfg_err), 32'(m_err));
    din_valid = 0;
    cfg_load  = 0;
    cnt_clr   = 0;
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl,
                      input bit v = 0, input bit d = 0);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    step(v, d, 1, 0, "load");
  endtask

  task automatic stream(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0, 0, tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".match"}, 32'(match), 0);
    chk({tag, ".count"}, 32'(match_count), 0);
    chk({tag, ".sat"},   32'(cnt_sat), 0);
    chk({tag, ".armed"}, 32'(armed), 0);
    chk({tag, ".err"},   32'(cfg_err), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #2;
    model_reset();
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1;
    din_valid   = 0;
    din         = 0;
    cfg_load    = 0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 0;
    cnt_clr     = 0;
    m_hits      = 0;
    dut_hits    = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    check_all_zero("reset_release");

    // 1: overlapping 1011; the bit sent with the load is dropped
    load(8'h0B, 4, 1, 1, 1);
    stream(32'b1011011, 7, "t1");
    chk("t1_total", 32'(match_count), 2);

    // 2: non-overlapping 1011
    step(0, 0, 0, 1, "t2_clr");
    load(8'h0B, 4, 0);
    stream(32'b1011011, 7, "t2");
    chk("t2_total", 32'(match_count), 1);

    // 3: valid gaps inside 1011, then reset mid-pattern
    step(0, 0, 0, 1, "t3_clr");
    load(8'h0B, 4, 1);
    step(1, 1, 0, 0, "t3");
    step(0, 0, 0, 0, "t3_gap");
    step(1, 0, 0, 0, "t3");
    step(0, 1, 0, 0, "t3_gap");
    step(0, 1, 0, 0, "t3_gap");
    step(1, 1, 0, 0, "t3");
    step(0, 0, 0, 0, "t3_gap");
    step(1, 1, 0, 0, "t3_last");
    chk("t3_pulse", 32'(match), 1);
    step(0, 0, 0, 0, "t3_after");
    chk("t3_pulse_end", 32'(match), 0);
    step(0, 0, 0, 1, "t3_clr2");
    load(8'h0B, 4, 1);
    stream(32'b101, 3, "t3_partial");
    do_reset("t3_rst");
    step(1, 1, 0, 0, "t3_post");
    check_all_zero("t3_post_zero");

    // 4: illegal lengths, then a legal reload
    load(8'h0B, 0, 1);
    chk("t4_err_len0", 32'(cfg_err), 1);
    chk("t4_armed_len0", 32'(armed), 0);
    stream(32'b10111011, 8, "t4_idle");
    load(8'h0B, 9, 1);
    chk("t4_err_len9", 32'(cfg_err), 1);
    stream(32'b1011, 4, "t4_idle9");
    load(8'h0B, 4, 1);
    chk("t4_err_clear", 32'(cfg_err), 0);
    chk("t4_armed", 32'(armed), 1);

    // 5: saturation and clear coincident with a hit
    load(8'h01, 1, 1);
    step(0, 0, 0, 1, "t5_clr");
    stream(32'b11111, 5, "t5");
    chk("t5_count", 32'(match_count), 3);
    chk("t5_sat", 32'(cnt_sat), 1);
    step(1, 1, 0, 1, "t5_clrhit");
    chk("t5_clrhit_pulse", 32'(match), 1);
    chk("t5_clrhit_count", 32'(match_count), 0);
    chk("t5_clrhit_sat", 32'(cnt_sat), 0);

    // 6: full-length A5 in a random stream with random valid gaps
    step(0, 0, 0, 1, "t6_clr");
    load(8'hA5, 8, 1);
    m_hits   = 0;
    dut_hits = 0;
    for (int i = 0; i < 400; i++) begin
      if ((i % 40) == 7) begin
        stream(32'hA5, 8, "t6_emb");
      end else begin
        step(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 0, 0, "t6_rnd");
      end
    end
    chk("t6_hit_total", 32'(dut_hits), 32'(m_hits));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
